// File: rtl/skolem_ic_sweeper.sv
// skolem_ic_sweeper: exhaustive (s, t) sweep of a combinational
// invertibility-condition circuit for the literal (x >>a s) op t.
// For every pair the ground truth "exists x" is found by walking x
// internally. That truth is compared with the circuit's registered
// output. The block counts mismatches and keeps the first failing pair.
//
// Handshake: start is a level sampled only in IDLE, so a start seen in
// any other state is ignored. done is a single-cycle pulse. pass,
// mismatch_count and fail_* are valid while done is high and hold
// until the next accepted start.
module skolem_ic_sweeper #(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [1:0]     op,
    output logic [W-1:0]   sk_s,
    output logic [W-1:0]   sk_t,
    input  logic           sk_out,
    output logic           busy,
    output logic           done,
    output logic           pass,
    output logic [2*W:0]   mismatch_count,
    output logic           fail_valid,
    output logic [W-1:0]   fail_s,
    output logic [W-1:0]   fail_t,
    output logic [2:0]     state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_APPLY   = 3'd1,
        S_SEARCH  = 3'd2,
        S_COMPARE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam logic [W:0] WIDTH_V = W;

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       op_q;
    logic [2*W-1:0]   p;
    logic [W-1:0]     x;
    logic             sk_q;
    logic             truth;
    logic [W-1:0]     r;
    logic             hit;
    logic             mis;
    logic [2*W:0]     count_nxt;
    logic             p_last;
    logic             x_last;

    // The pair index drives the checked circuit directly: s is the outer loop, t the inner.
    assign sk_s   = p[2*W-1:W];
    assign sk_t   = p[W-1:0];
    assign p_last = &p;
    assign x_last = &x;

    // Arithmetic shift of the candidate x. Shifts of W or more leave only the sign bit.
    always_comb begin
        r = '0;
        if ({1'b0, sk_s} >= WIDTH_V) begin
            r = {W{x[W-1]}};
        end else begin
            r = $unsigned($signed(x) >>> sk_s);
        end
    end

    // Relation between the shifted candidate and t, using the op latched at start.
    always_comb begin
        hit = 1'b0;
        case (op_q)
            2'b00:   hit = (r >= sk_t);
            2'b01:   hit = (r >  sk_t);
            2'b10:   hit = (r <  sk_t);
            default: hit = (r == sk_t);
        endcase
    end

    // Mismatch of the registered circuit output against truth, and the resulting count.
    always_comb begin
        mis       = (sk_q != truth);
        count_nxt = mismatch_count + {{(2*W){1'b0}}, mis};
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. SEARCH exits on the first hit or after the last x.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start) state_nxt = S_APPLY;
            S_APPLY:   state_nxt = S_SEARCH;
            S_SEARCH:  if (hit || x_last) state_nxt = S_COMPARE;
            S_COMPARE: state_nxt = p_last ? S_DONE : S_APPLY;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Status outputs decoded from state, so busy and done are never high together.
    always_comb begin
        busy      = (state == S_APPLY) || (state == S_SEARCH) || (state == S_COMPARE);
        done      = (state == S_DONE);
        state_dbg = state;
    end

    // Datapath: pair and x counters, truth, the sampled circuit output and results.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q           <= 2'b00;
            p              <= '0;
            x              <= '0;
            sk_q           <= 1'b0;
            truth          <= 1'b0;
            pass           <= 1'b0;
            mismatch_count <= '0;
            fail_valid     <= 1'b0;
            fail_s         <= '0;
            fail_t         <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q           <= op;
                        p              <= '0;
                        pass           <= 1'b0;
                        mismatch_count <= '0;
                        fail_valid     <= 1'b0;
                        fail_s         <= '0;
                        fail_t         <= '0;
                    end
                end
                S_APPLY: begin
                    // sk_s/sk_t have been stable since the edge that entered APPLY.
                    sk_q <= sk_out;
                    x    <= '0;
                end
                S_SEARCH: begin
                    truth <= hit;
                    if (!hit && !x_last) begin
                        x <= x + 1'b1;
                    end
                end
                S_COMPARE: begin
                    mismatch_count <= count_nxt;
                    if (mis && !fail_valid) begin
                        fail_valid <= 1'b1;
                        fail_s     <= sk_s;
                        fail_t     <= sk_t;
                    end
                    if (p_last) begin
                        pass <= (count_nxt == '0);
                    end else begin
                        p <= p + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
